// File: rtl/oclib_pkg.sv
// Shared parameter constants and APB / CSR bus structures for the oclib blocks.
package oclib_pkg;

  localparam bit True  = 1'b1;
  localparam bit False = 1'b0;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] wdata;
  } csr_32_s;

  typedef struct packed {
    logic        ready;
    logic        error;
    logic [31:0] rdata;
  } csr_32_fb_s;

  typedef struct packed {
    logic        select;
    logic        enable;
    logic        write;
    logic [19:0] address;
    logic [31:0] wdata;
  } apb_s;

  typedef struct packed {
    logic        ready;
    logic        error;
    logic [31:0] rdata;
  } apb_fb_s;

endpackage

// File: rtl/oclib_module_reset.sv
// Optional reset synchronizer followed by an optional reset pipeline.
module oclib_module_reset #(
  parameter bit ResetSync     = 1'b0,
  parameter int SyncCycles    = 3,
  parameter int ResetPipeline = 0
) (
  input  logic clock,
  input  logic reset,
  output logic resetOut
);

  logic synced;

  if (ResetSync) begin : g_sync
    logic [SyncCycles-1:0] sync_d;
    logic [SyncCycles-1:0] sync_q;

    // shift the raw reset through the synchronizer chain
    always_comb begin
      sync_d[0] = reset;
      for (int i = 1; i < SyncCycles; i++) begin
        sync_d[i] = sync_q[i-1];
      end
    end

    always_ff @(posedge clock) begin
      sync_q <= sync_d;
    end

    assign synced = sync_q[SyncCycles-1];
  end else begin : g_nosync
    assign synced = reset;
  end

  if (ResetPipeline > 0) begin : g_pipe
    logic [ResetPipeline-1:0] pipe_d;
    logic [ResetPipeline-1:0] pipe_q;

    // retiming stages so a widely fanned-out reset can be placed freely
    always_comb begin
      pipe_d[0] = synced;
      for (int i = 1; i < ResetPipeline; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end

    always_ff @(posedge clock) begin
      pipe_q <= pipe_d;
    end

    assign resetOut = pipe_q[ResetPipeline-1];
  end else begin : g_nopipe
    assign resetOut = synced;
  end

endmodule

// File: rtl/oclib_apb_to_csr.sv
// APB completer to CSR initiator bridge: one transfer in flight, optional
// CSR timeout that completes the APB transfer with an error.
module oclib_apb_to_csr #(
  parameter type CsrType       = oclib_pkg::csr_32_s,
  parameter type CsrFbType     = oclib_pkg::csr_32_fb_s,
  parameter type ApbType       = oclib_pkg::apb_s,
  parameter type ApbFbType     = oclib_pkg::apb_fb_s,
  parameter bit  ApbSlaveError = oclib_pkg::True,
  parameter int  TimeoutCycles = 64,
  parameter int  SyncCycles    = 3,
  parameter bit  ResetSync     = oclib_pkg::False,
  parameter int  ResetPipeline = 0
) (
  input  logic     clock,
  input  logic     reset,
  input  ApbType   apb,
  output ApbFbType apbFb,
  output CsrType   csr,
  input  CsrFbType csrFb
);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRequest  = 2'd1,
    StResponse = 2'd2
  } state_e;

  localparam int TimerW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

  state_e            state_d;
  state_e            state_q;
  CsrType            csr_d;
  CsrType            csr_q;
  ApbFbType          apb_fb_d;
  ApbFbType          apb_fb_q;
  logic [TimerW-1:0] timer_d;
  logic [TimerW-1:0] timer_q;
  logic              timeout_hit;
  logic              reset_sync;
  logic              unused_enable;

  localparam int CsrAddrW  = $bits(csr_q.address);
  localparam int CsrDataW  = $bits(csr_q.wdata);
  localparam int ApbRdataW = $bits(apb_fb_q.rdata);

  oclib_module_reset #(
    .ResetSync     (ResetSync),
    .SyncCycles    (SyncCycles),
    .ResetPipeline (ResetPipeline)
  ) u_reset (
    .clock    (clock),
    .reset    (reset),
    .resetOut (reset_sync)
  );

  // enable is guaranteed by the APB protocol before ready is sampled
  assign unused_enable = apb.enable;

  assign timeout_hit = (TimeoutCycles > 0) && (timer_q == TimerW'(TimeoutCycles));

  // next-state, request and response computation
  always_comb begin
    state_d        = state_q;
    csr_d          = csr_q;
    apb_fb_d       = apb_fb_q;
    apb_fb_d.ready = 1'b0;
    timer_d        = timer_q;
    case (state_q)
      StIdle: begin
        if (apb.select) begin
          csr_d         = '0;
          csr_d.address = CsrAddrW'(apb.address);
          csr_d.wdata   = CsrDataW'(apb.wdata);
          csr_d.write   = apb.write;
          csr_d.read    = !apb.write;
          timer_d       = '0;
          state_d       = StRequest;
        end else begin
          state_d = StIdle;
        end
      end
      StRequest: begin
        if (csrFb.ready) begin
          apb_fb_d.ready = 1'b1;
          apb_fb_d.rdata = csr_q.write ? '0 : ApbRdataW'(csrFb.rdata);
          apb_fb_d.error = csrFb.error & ApbSlaveError;
          csr_d.read     = 1'b0;
          csr_d.write    = 1'b0;
          state_d        = StResponse;
        end else if (timeout_hit) begin
          apb_fb_d.ready = 1'b1;
          apb_fb_d.rdata = '0;
          apb_fb_d.error = ApbSlaveError;
          csr_d.read     = 1'b0;
          csr_d.write    = 1'b0;
          state_d        = StResponse;
        end else if (timer_q < TimerW'(TimeoutCycles)) begin
          timer_d = timer_q + TimerW'(1);
        end else begin
          timer_d = timer_q;
        end
      end
      StResponse: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // state and registered outputs; a reset abandons any transfer in flight
  always_ff @(posedge clock) begin
    if (reset_sync) begin
      state_q  <= StIdle;
      csr_q    <= '0;
      apb_fb_q <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      csr_q    <= csr_d;
      apb_fb_q <= apb_fb_d;
      timer_q  <= timer_d;
    end
  end

  assign csr   = csr_q;
  assign apbFb = apb_fb_q;

endmodule

// File: tb/tb_oclib_apb_to_csr.sv
// Scoreboard bench for oclib_apb_to_csr: stimulus queues expected CSR requests
// and APB responses, a negedge monitor pops and compares them.
module tb_oclib_apb_to_csr;

  logic                   clk;
  logic                   rst;
  oclib_pkg::apb_s        apb_in;
  oclib_pkg::apb_fb_s     apb_fb_o;
  oclib_pkg::apb_fb_s     apb_fb_ne_o;
  oclib_pkg::csr_32_s     csr_o;
  oclib_pkg::csr_32_s     csr_ne_o;
  oclib_pkg::csr_32_fb_s  csr_fb_in;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_exp_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] lat;
  } rsp_exp_t;

  req_exp_t req_q[$];
  rsp_exp_t rsp_q[$];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int req_cyc = 0;
  bit mon_en = 1'b0;
  bit req_prev = 1'b0;
  bit ready_prev = 1'b0;

  oclib_apb_to_csr #(
    .ApbSlaveError (oclib_pkg::True),
    .TimeoutCycles (4)
  ) dut (
    .clock (clk),
    .reset (rst),
    .apb   (apb_in),
    .apbFb (apb_fb_o),
    .csr   (csr_o),
    .csrFb (csr_fb_in)
  );

  oclib_apb_to_csr #(
    .ApbSlaveError (oclib_pkg::False),
    .TimeoutCycles (4)
  ) dut_ne (
    .clock (clk),
    .reset (rst),
    .apb   (apb_in),
    .apbFb (apb_fb_ne_o),
    .csr   (csr_ne_o),
    .csrFb (csr_fb_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function void chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function void flag(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: event seen/missing contrary to expectation", name);
  endfunction

  // monitor: compare each new CSR request and each APB completion
  always @(negedge clk) begin
    req_exp_t re;
    rsp_exp_t rp;
    bit       req_now;
    cyc++;
    req_now = csr_o.read | csr_o.write;
    if (mon_en) begin
      if (req_now && !req_prev) begin
        req_cyc = cyc;
        if (req_q.size() == 0) begin
          flag("unexpected_csr_request");
        end else begin
          re = req_q.pop_front();
          chk("csr_write", 96'(csr_o.write), 96'(re.wr));
          chk("csr_read", 96'(csr_o.read), 96'(!re.wr));
          chk("csr_address", 96'(csr_o.address), 96'(re.addr));
          chk("csr_wdata", 96'(csr_o.wdata), 96'(re.wdata));
        end
      end
      if (apb_fb_o.ready) begin
        chk("ready_single_pulse", 96'(ready_prev), 96'(0));
        if (rsp_q.size() == 0) begin
          flag("unexpected_apb_ready");
        end else begin
          rp = rsp_q.pop_front();
          chk("apb_rdata", 96'(apb_fb_o.rdata), 96'(rp.rdata));
          chk("apb_error", 96'(apb_fb_o.error), 96'(rp.err));
          chk("latency", 96'(cyc - req_cyc), 96'(rp.lat));
          chk("ne_ready", 96'(apb_fb_ne_o.ready), 96'(1));
          chk("ne_error", 96'(apb_fb_ne_o.error), 96'(0));
          chk("ne_rdata", 96'(apb_fb_ne_o.rdata), 96'(rp.rdata));
        end
      end
    end
    req_prev   = req_now;
    ready_prev = apb_fb_o.ready;
  end

  // present a setup, wait for the request, answer it after 'stall' request cycles (-1: never)
  task automatic xfer(input bit wr, input logic [19:0] a, input logic [31:0] wd,
                      input int stall, input logic [31:0] crd, input bit cerr,
                      input logic [31:0] erd, input bit eerr, input int elat);
    bit seen;
    bit done;
    req_q.push_back('{wr, {12'h000, a}, wd});
    rsp_q.push_back('{erd, eerr, 32'(elat)});
    apb_in.select  = 1'b1;
    apb_in.enable  = 1'b0;
    apb_in.write   = wr;
    apb_in.address = a;
    apb_in.wdata   = wd;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge clk);
      #1;
      apb_in.enable = 1'b1;
      if (csr_o.read | csr_o.write) seen = 1'b1;
    end
    if (!seen) flag("csr_request_timeout");
    done = 1'b0;
    for (int i = 0; i < 40 && seen && !done; i++) begin
      csr_fb_in.ready = (i == stall);
      csr_fb_in.rdata = crd;
      csr_fb_in.error = cerr;
      @(posedge clk);
      #1;
      csr_fb_in.ready = 1'b0;
      if (apb_fb_o.ready) done = 1'b1;
    end
    if (seen && !done) flag("apb_ready_timeout");
    apb_in.select = 1'b0;
    apb_in.enable = 1'b0;
  endtask

  initial begin
    bit seen;
    rst       = 1'b1;
    apb_in    = '0;
    csr_fb_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_csr", 96'(csr_o), 96'(0));
    chk("reset_apbfb", 96'(apb_fb_o), 96'(0));
    rst    = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // write, CSR ready two cycles into the request, csr rdata must be masked
    xfer(1'b1, 20'h00010, 32'hCAFE0001, 2, 32'h5555AAAA, 1'b0, 32'h0, 1'b0, 3);
    repeat (2) @(posedge clk);
    #1;
    // read with CSR error
    xfer(1'b0, 20'h00024, 32'h0, 0, 32'h12345678, 1'b1, 32'h12345678, 1'b1, 1);
    repeat (2) @(posedge clk);
    #1;
    // CSR never answers: timeout five cycles after the request
    xfer(1'b0, 20'h00030, 32'h0, -1, 32'h0, 1'b0, 32'h0, 1'b1, 5);
    csr_fb_in.ready = 1'b1;
    csr_fb_in.rdata = 32'h00000BAD;
    repeat (3) @(posedge clk);
    #1;
    csr_fb_in.ready = 1'b0;
    chk("hold_rdata", 96'(apb_fb_o.rdata), 96'(0));
    chk("hold_error", 96'(apb_fb_o.error), 96'(1));
    // ready on the very cycle the timeout expires: completion wins
    xfer(1'b0, 20'h00040, 32'h0, 4, 32'hA5A50F0F, 1'b0, 32'hA5A50F0F, 1'b0, 5);
    repeat (2) @(posedge clk);
    #1;
    // back-to-back write then read
    xfer(1'b1, 20'h00050, 32'h11112222, 1, 32'hFFFF0000, 1'b0, 32'h0, 1'b0, 2);
    xfer(1'b0, 20'h00054, 32'h0, 0, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b1, 1);
    repeat (2) @(posedge clk);
    #1;

    // reset while the request is outstanding
    req_q.push_back('{1'b0, 32'h00000060, 32'h0});
    apb_in.select  = 1'b1;
    apb_in.write   = 1'b0;
    apb_in.address = 20'h00060;
    apb_in.wdata   = 32'h0;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge clk);
      #1;
      apb_in.enable = 1'b1;
      if (csr_o.read | csr_o.write) seen = 1'b1;
    end
    if (!seen) flag("reset_case_request_timeout");
    @(posedge clk);
    #1;
    rst    = 1'b1;
    apb_in = '0;
    @(posedge clk);
    #1;
    chk("midreset_csr", 96'(csr_o), 96'(0));
    chk("midreset_apbfb", 96'(apb_fb_o), 96'(0));
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // transfer after reset, with a 20-bit address that must zero-extend
    xfer(1'b1, 20'hFFFFC, 32'h0BADF00D, 3, 32'h0, 1'b0, 32'h0, 1'b0, 4);

    for (int i = 0; i < 20 && (req_q.size() != 0 || rsp_q.size() != 0); i++) begin
      @(posedge clk);
    end
    if (req_q.size() != 0) flag("pending_csr_requests");
    if (rsp_q.size() != 0) flag("pending_apb_responses");
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/oclib_apb_to_csr.md
OCLIB_APB_TO_CSR -- requirements
Module: oclib_apb_to_csr

Interface
REQ-001 Parameters SHALL be as follows (name, default, meaning):
- CsrType, oclib_pkg::csr_32_s, CSR request struct.
- CsrFbType, oclib_pkg::csr_32_fb_s, CSR feedback struct.
- ApbType, oclib_pkg::apb_s, APB request struct.
- ApbFbType, oclib_pkg::apb_fb_s, APB feedback struct.
- ApbSlaveError, oclib_pkg::True, when False apbFb.error is forced to 0.
- TimeoutCycles, 64, CSR wait limit in cycles; 0 disables the timeout.
- SyncCycles, 3, reset synchronizer depth.
- ResetSync, oclib_pkg::False, enables the reset synchronizer.
- ResetPipeline, 0, reset pipeline stages.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clock, input, 1, sole clock.
- reset, input, 1, synchronous active-high reset.
- apb, input, ApbType, APB requester (select, enable, write, address, wdata).
- apbFb, output, ApbFbType, APB completer response (ready, error, rdata).
- csr, output, CsrType, CSR request (read, write, address, wdata).
- csrFb, input, CsrFbType, CSR response (ready, error, rdata).
REQ-003 Reset SHALL pass through oclib_module_reset (ResetSync, SyncCycles, ResetPipeline) to form internal resetSync.

Function
REQ-004 The block SHALL implement the APB completer side and the CSR initiator side, with one transfer in flight at a time.
REQ-005 The state machine SHALL have exactly three states: StIdle, StRequest, StResponse.
REQ-006 In StIdle with apb.select=1 (any enable value), the block SHALL capture address and wdata into csr.address/csr.wdata, set csr.write=apb.write and csr.read=!apb.write, clear the timeout counter, and go to StRequest.
REQ-007 csr.address and csr.wdata SHALL be zero-extended or truncated to the CsrType field widths; all other CsrType fields SHALL be held at 0.
REQ-008 In StRequest, csr.read/csr.write SHALL be held until csrFb.ready=1 is sampled.
REQ-009 On csrFb.ready=1 in StRequest, the next cycle SHALL show apbFb.ready=1, apbFb.rdata=csrFb.rdata (reads; 0 for writes), apbFb.error=csrFb.error&ApbSlaveError, csr.read=csr.write=0, state=StResponse.
REQ-010 Timeout: after TimeoutCycles consecutive StRequest cycles without csrFb.ready (TimeoutCycles>0), the next cycle SHALL show apbFb.ready=1, apbFb.error=ApbSlaveError, apbFb.rdata=0, csr.read=csr.write=0, state=StResponse.
REQ-011 If csrFb.ready and the timeout occur in the same cycle, the normal completion (REQ-009) SHALL win.
REQ-012 The timeout counter SHALL be $clog2(TimeoutCycles+1) bits wide and SHALL saturate, never wrap.
REQ-013 apbFb.ready SHALL be a single-cycle pulse.
REQ-014 In StResponse, apbFb.ready SHALL clear to 0 and the state SHALL return unconditionally to StIdle.
REQ-015 apbFb.rdata and apbFb.error SHALL hold their values until the next completion.
REQ-016 csrFb SHALL be ignored outside StRequest, so a late ready after a timeout is discarded.
REQ-017 Latency: setup in cycle 0 gives csr request visible in cycle 1. With csrFb.ready in cycle k, apbFb.ready is high in cycle k+1.
REQ-018 Back-to-back transfers: a new setup presented in the StResponse cycle SHALL be accepted in the following StIdle cycle with no lost transfer.
REQ-019 apb.enable SHALL NOT gate acceptance or completion; the APB protocol guarantees enable=1 by the time ready is sampled.

Reset
REQ-020 On resetSync: state=StIdle, csr='0, apbFb='0, timeout counter=0.
REQ-021 Reset mid-transfer SHALL abandon the transfer without generating an apbFb.ready pulse; the APB requester is reset alongside.

Verification
REQ-022 Write: apb addr=0x10, wdata=0xCAFE0001, CSR ready 2 cycles after request -> csr.write=1 with matching addr/data, apbFb.ready pulse of 1 cycle, error=0.
REQ-023 Read: addr=0x24, csrFb.rdata=0x12345678, error=1 -> apbFb.rdata=0x12345678, error=1. Repeat with ApbSlaveError=False -> error=0.
REQ-024 Timeout: TimeoutCycles=4, CSR never ready -> apbFb.ready exactly 5 cycles after csr request, error=1, rdata=0. A late csrFb.ready is ignored.
REQ-025 Tie: csrFb.ready in the same cycle the timeout expires -> completion with csrFb.rdata, no timeout error.
REQ-026 Back-to-back: write then read with no idle cycle -> two csr requests, two ready pulses, no duplicate request.
REQ-027 Reset asserted in StRequest -> outputs zero next cycle, no apbFb.ready pulse; a subsequent transfer completes normally.
